// File: rtl/interleaver_arbiter.sv
// Block-granular round-robin scheduler sharing one interleaver among ch_num 1-bit
// AXI-Stream sources; tags every interleaved output block with its source channel ID.
module interleaver_arbiter #(
  parameter int ch_num     = 4,
  parameter int id_width   = 2,
  parameter int row        = 512,
  parameter int col        = 32,
  parameter int tag_deepth = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  // channel sources
  input  logic [ch_num-1:0]   s_axis_tdata,
  input  logic [ch_num-1:0]   s_axis_tvalid,
  output logic [ch_num-1:0]   s_axis_tready,
  // interleaver input side
  output logic                il_s_axis_tdata,
  output logic                il_s_axis_tvalid,
  input  logic                il_s_axis_tready,
  // interleaver output side
  input  logic                il_m_axis_tdata,
  input  logic                il_m_axis_tvalid,
  input  logic                il_m_axis_tlast,
  output logic                il_m_axis_tready,
  // forwarded, tagged output
  output logic                m_axis_tdata,
  output logic                m_axis_tvalid,
  output logic                m_axis_tlast,
  output logic [id_width-1:0] m_axis_tuser,
  input  logic                m_axis_tready,
  // status
  output logic [id_width-1:0] grant,
  output logic                busy
);

  localparam int blk_len = row * col;
  localparam int cnt_w   = (blk_len > 1) ? $clog2(blk_len) : 1;
  localparam int tag_aw  = $clog2(tag_deepth);

  localparam logic [cnt_w-1:0]    last_beat  = cnt_w'(blk_len - 1);
  localparam logic [id_width:0]   ch_num_ext = (id_width + 1)'(ch_num);
  localparam logic [id_width-1:0] last_ch    = id_width'(ch_num - 1);
  localparam logic [tag_aw:0]     tag_full   = (tag_aw + 1)'(tag_deepth);

  typedef enum logic {
    ARB  = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [id_width-1:0] rr_ptr;
  logic [cnt_w-1:0]    beat_cnt;

  logic [id_width-1:0] req_sel;
  logic                req_found;
  logic [id_width:0]   cand;

  logic arb_go;
  logic xfer_hs;
  logic blk_done;

  logic [id_width-1:0] tag_mem [tag_deepth];
  logic [tag_aw-1:0]   tag_wr_ptr;
  logic [tag_aw-1:0]   tag_rd_ptr;
  logic [tag_aw:0]     tag_cnt;
  logic                fifo_full;
  logic                fifo_empty;
  logic                tag_push;
  logic                tag_pop;

  // Round-robin pick: scan channels starting at rr_ptr, wrapping at ch_num.
  // NOTE: always_comb temporaries like cand use blocking '=' so each loop
  // iteration sees the value just computed; registers below use '<=' only.
  always_comb begin
    req_found = 1'b0;
    req_sel   = '0;
    cand      = '0;
    for (int i = 0; i < ch_num; i++) begin
      cand = {1'b0, rr_ptr} + (id_width + 1)'(i);
      if (cand >= ch_num_ext) begin
        cand = cand - ch_num_ext;
      end
      if (!req_found && s_axis_tvalid[cand[id_width-1:0]]) begin
        req_found = 1'b1;
        req_sel   = cand[id_width-1:0];
      end
    end
  end

  assign arb_go   = (state == ARB) && req_found && !fifo_full;
  assign xfer_hs  = (state == XFER) && il_s_axis_tvalid && il_s_axis_tready;
  assign blk_done = xfer_hs && (beat_cnt == last_beat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of a combinational block gets a default before the
  // case statement, otherwise an unassigned path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (arb_go)   state_nxt = XFER;
      XFER:    if (blk_done) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  // Input mux: the granted channel drives the interleaver directly, no pipeline.
  always_comb begin
    s_axis_tready    = '0;
    il_s_axis_tdata  = 1'b0;
    il_s_axis_tvalid = 1'b0;
    if (state == XFER) begin
      il_s_axis_tdata       = s_axis_tdata[grant];
      il_s_axis_tvalid      = s_axis_tvalid[grant];
      s_axis_tready[grant]  = il_s_axis_tready;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant  <= '0;
      rr_ptr <= '0;
    end else if (arb_go) begin
      grant  <= req_sel;
      rr_ptr <= (req_sel == last_ch) ? '0 : req_sel + 1'b1;
    end
  end

  // beat_cnt only moves on a handshake, so a stalled source freezes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (blk_done) begin
      beat_cnt <= '0;
    end else if (xfer_hs) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // Tag FIFO: one entry per block handed to the interleaver, retired on the
  // tlast handshake of the matching output block.
  assign fifo_full  = (tag_cnt == tag_full);
  assign fifo_empty = (tag_cnt == '0);
  assign tag_push   = arb_go;
  assign tag_pop    = m_axis_tvalid && m_axis_tready && il_m_axis_tlast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
      tag_cnt    <= '0;
    end else begin
      if (tag_push) tag_wr_ptr <= tag_wr_ptr + 1'b1;
      if (tag_pop)  tag_rd_ptr <= tag_rd_ptr + 1'b1;
      case ({tag_push, tag_pop})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  // NOTE: the tag storage is deliberately not reset; the pointers and count
  // are, and the head is masked to 0 while empty, so stale entries never leak.
  always_ff @(posedge clk) begin
    if (tag_push) begin
      tag_mem[tag_wr_ptr] <= req_sel;
    end
  end

  assign m_axis_tdata     = il_m_axis_tdata;
  assign m_axis_tlast     = il_m_axis_tlast;
  assign m_axis_tvalid    = il_m_axis_tvalid && !fifo_empty;
  assign il_m_axis_tready = m_axis_tready && !fifo_empty;
  assign m_axis_tuser     = fifo_empty ? '0 : tag_mem[tag_rd_ptr];

  assign busy = (state == XFER);

endmodule

// File: tb/tb_interleaver_arbiter.sv
// Directed bench for interleaver_arbiter with 4 channels and 8-beat blocks; the bench
// plays the interleaver output side itself and checks tags, grants and block lengths.
module tb_interleaver_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] s_axis_tdata;
  logic [3:0] s_axis_tvalid;
  logic [3:0] s_axis_tready;
  logic       il_s_axis_tdata;
  logic       il_s_axis_tvalid;
  logic       il_s_axis_tready;
  logic       il_m_axis_tdata;
  logic       il_m_axis_tvalid;
  logic       il_m_axis_tlast;
  logic       il_m_axis_tready;
  logic       m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tlast;
  logic [1:0] m_axis_tuser;
  logic       m_axis_tready;
  logic [1:0] grant;
  logic       busy;

  interleaver_arbiter #(
    .ch_num(4), .id_width(2), .row(4), .col(2), .tag_deepth(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .il_s_axis_tdata(il_s_axis_tdata), .il_s_axis_tvalid(il_s_axis_tvalid),
    .il_s_axis_tready(il_s_axis_tready),
    .il_m_axis_tdata(il_m_axis_tdata), .il_m_axis_tvalid(il_m_axis_tvalid),
    .il_m_axis_tlast(il_m_axis_tlast), .il_m_axis_tready(il_m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .m_axis_tready(m_axis_tready),
    .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int blk_grant[$];
  int blk_beats[$];
  int hs_cyc[$];
  int cyc;
  int data_err;
  int rdy_err;
  logic [3:0] rdy_mask;
  logic busy_q;

  int exp_all[5] = '{0, 1, 2, 3, 0};
  int exp_odd[4] = '{1, 3, 1, 3};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observe one cycle at the falling edge: log block starts, handshakes, stray readies.
  task automatic sample();
    @(negedge clk);
    if (busy && !busy_q) begin
      blk_grant.push_back(int'(grant));
      blk_beats.push_back(0);
    end
    if (il_s_axis_tvalid && il_s_axis_tready) begin
      hs_cyc.push_back(cyc);
      if (blk_beats.size() > 0) blk_beats[blk_beats.size()-1]++;
      if (il_s_axis_tdata !== s_axis_tdata[grant]) data_err++;
    end
    if ((s_axis_tready & ~rdy_mask) != 4'b0000) rdy_err++;
    busy_q = busy;
    cyc++;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    s_axis_tdata = 4'($urandom);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      sample();
      adv();
    end
  endtask

  task automatic clear_logs();
    blk_grant.delete();
    blk_beats.delete();
    hs_cyc.delete();
    cyc      = 0;
    data_err = 0;
    rdy_err  = 0;
    rdy_mask = 4'hF;
    busy_q   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    s_axis_tvalid    = 4'h0;
    il_m_axis_tvalid = 1'b0;
    il_m_axis_tlast  = 1'b0;
    il_m_axis_tdata  = 1'b0;
    m_axis_tready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_logs();
  endtask

  // Play one 8-beat interleaver output block and check it is forwarded with exp_tag.
  task automatic out_block(input logic [1:0] exp_tag);
    m_axis_tready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      il_m_axis_tvalid = 1'b1;
      il_m_axis_tlast  = (b == 7);
      il_m_axis_tdata  = b[0];
      sample();
      check("out_tuser", 32'(m_axis_tuser), 32'(exp_tag));
      check("out_tvalid", 32'(m_axis_tvalid), 32'd1);
      check("out_tlast", 32'(m_axis_tlast), 32'(b == 7));
      check("out_tdata", 32'(m_axis_tdata), 32'(b[0]));
      adv();
    end
    il_m_axis_tvalid = 1'b0;
    il_m_axis_tlast  = 1'b0;
    m_axis_tready    = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 30) begin
      sample();
      adv();
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    clear_logs();
    // Reset values, with every input pushing to make the zeros meaningful.
    rst_n            = 1'b0;
    s_axis_tdata     = 4'hF;
    s_axis_tvalid    = 4'hF;
    il_s_axis_tready = 1'b1;
    il_m_axis_tvalid = 1'b1;
    il_m_axis_tlast  = 1'b1;
    il_m_axis_tdata  = 1'b0;
    m_axis_tready    = 1'b1;
    #3;
    check("rst_s_tready", 32'(s_axis_tready), 32'd0);
    check("rst_il_tvalid", 32'(il_s_axis_tvalid), 32'd0);
    check("rst_il_tdata", 32'(il_s_axis_tdata), 32'd0);
    check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_m_tuser", 32'(m_axis_tuser), 32'd0);
    check("rst_il_m_tready", 32'(il_m_axis_tready), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Only ch2 valid: two blocks, handshakes in cycles 1..8 and 10..17.
    do_reset();
    s_axis_tvalid = 4'b0100;
    rdy_mask      = 4'b0100;
    run(18);
    s_axis_tvalid = 4'h0;
    check("a_nhs", 32'(hs_cyc.size()), 32'd16);
    if (hs_cyc.size() == 16) begin
      check("a_first_hs", 32'(hs_cyc[0]), 32'd1);
      check("a_second_blk_hs", 32'(hs_cyc[8]), 32'd10);
      check("a_last_hs", 32'(hs_cyc[15]), 32'd17);
    end
    check("a_nblk", 32'(blk_grant.size()), 32'd2);
    check("a_grant", 32'(grant), 32'd2);
    check("a_busy_idle", 32'(busy), 32'd0);
    check("a_data", 32'(data_err), 32'd0);
    check("a_ready", 32'(rdy_err), 32'd0);
    out_block(2'd2);
    out_block(2'd2);
    il_m_axis_tvalid = 1'b1;
    m_axis_tready    = 1'b1;
    sample();
    check("a_empty_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("a_empty_tready", 32'(il_m_axis_tready), 32'd0);
    check("a_empty_tuser", 32'(m_axis_tuser), 32'd0);
    adv();

    // All channels valid, output stalled: four blocks fill the tag FIFO.
    do_reset();
    s_axis_tvalid = 4'hF;
    run(36);
    for (int i = 0; i < 5; i++) begin
      sample();
      check("b_full_busy", 32'(busy), 32'd0);
      check("b_full_ready", 32'(s_axis_tready), 32'd0);
      adv();
    end
    check("b_full_grant", 32'(grant), 32'd3);
    check("b_full_nblk", 32'(blk_grant.size()), 32'd4);
    // Releasing the output pops tags 0,1,2,3 in order and arbitration resumes.
    out_block(2'd0);
    out_block(2'd1);
    out_block(2'd2);
    out_block(2'd3);
    wait_idle("b_idle_timeout");
    s_axis_tvalid = 4'h0;
    check("b_nblk_ge5", 32'(blk_grant.size() >= 5), 32'd1);
    if (blk_grant.size() >= 5) begin
      for (int i = 0; i < 5; i++) check("b_grant_order", 32'(blk_grant[i]), 32'(exp_all[i]));
    end
    for (int i = 0; i < blk_beats.size(); i++) check("b_blk_len", 32'(blk_beats[i]), 32'd8);
    check("b_data", 32'(data_err), 32'd0);

    // Only ch1 and ch3 valid: grants alternate, ch0/ch2 readies never rise.
    do_reset();
    s_axis_tvalid = 4'b1010;
    rdy_mask      = 4'b1010;
    run(36);
    s_axis_tvalid = 4'h0;
    check("c_nblk", 32'(blk_grant.size()), 32'd4);
    if (blk_grant.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("c_grant_order", 32'(blk_grant[i]), 32'(exp_odd[i]));
        check("c_blk_len", 32'(blk_beats[i]), 32'd8);
      end
    end
    check("c_ready", 32'(rdy_err), 32'd0);
    check("c_data", 32'(data_err), 32'd0);

    // ch0 drops valid for 5 cycles after 3 beats; block still ends after 8 beats.
    do_reset();
    s_axis_tvalid = 4'b0001;
    rdy_mask      = 4'b0001;
    run(4);
    s_axis_tvalid = 4'h0;
    for (int i = 0; i < 5; i++) begin
      sample();
      check("d_hold_busy", 32'(busy), 32'd1);
      check("d_hold_grant", 32'(grant), 32'd0);
      check("d_hold_ready", 32'(s_axis_tready), 32'd1);
      adv();
    end
    s_axis_tvalid = 4'b0001;
    run(4);
    sample();
    check("d_busy_last_beat", 32'(busy), 32'd1);
    adv();
    s_axis_tvalid = 4'h0;
    sample();
    check("d_busy_done", 32'(busy), 32'd0);
    adv();
    check("d_nblk", 32'(blk_grant.size()), 32'd1);
    if (blk_beats.size() == 1) check("d_blk_len", 32'(blk_beats[0]), 32'd8);
    check("d_data", 32'(data_err), 32'd0);

    // Reset pulsed at beat 3 of a ch1 block; next grant starts from ch0.
    do_reset();
    s_axis_tvalid = 4'b0010;
    run(4);
    il_m_axis_tvalid = 1'b1;
    m_axis_tready    = 1'b1;
    s_axis_tvalid    = 4'hF;
    #1;
    check("e_pre_busy", 32'(busy), 32'd1);
    check("e_pre_tuser", 32'(m_axis_tuser), 32'd1);
    check("e_pre_tvalid", 32'(m_axis_tvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("e_rst_busy", 32'(busy), 32'd0);
    check("e_rst_grant", 32'(grant), 32'd0);
    check("e_rst_ready", 32'(s_axis_tready), 32'd0);
    check("e_rst_il_tvalid", 32'(il_s_axis_tvalid), 32'd0);
    check("e_rst_il_tdata", 32'(il_s_axis_tdata), 32'd0);
    check("e_rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("e_rst_tuser", 32'(m_axis_tuser), 32'd0);
    check("e_rst_il_m_tready", 32'(il_m_axis_tready), 32'd0);
    @(posedge clk);
    #1;
    rst_n            = 1'b1;
    il_m_axis_tvalid = 1'b0;
    m_axis_tready    = 1'b0;
    clear_logs();
    run(1);
    check("e_after_grant", 32'(grant), 32'd0);
    check("e_after_busy", 32'(busy), 32'd1);
    check("e_after_ready", 32'(s_axis_tready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/interleaver_arbiter.md
# interleaver_arbiter

Block-granular round-robin scheduler that shares one interleaver (the mode=0 or mode=1 variant) among `ch_num` independent 1-bit AXI-Stream sources. It grants the interleaver input to one channel for exactly `row*col` accepted beats, then re-arbitrates. It also tags every interleaved output block with the ID of the channel that produced it. The block sits between the channel sources and the interleaver input, and monitors and forwards the interleaver output stream.

## Interface
- `ch_num`, 4: number of requesting channels, 2..16.
- `id_width`, 2: channel ID width; must be ≥ clog2(`ch_num`).
- `row`, 512: interleaver rows; must match the shared interleaver.
- `col`, 32: interleaver columns; must match the shared interleaver.
- `tag_deepth`, 4: tag FIFO depth (blocks in flight), power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `s_axis_tdata`  in  `ch_num`  one data bit per channel.
- `s_axis_tvalid`  in  `ch_num`  per-channel valid.
- `s_axis_tready`  out  `ch_num`  per-channel ready.
- `il_s_axis_tdata`  out  1  data to interleaver input.
- `il_s_axis_tvalid`  out  1  valid to interleaver input.
- `il_s_axis_tready`  in  1  ready from interleaver input.
- `il_m_axis_tdata`  in  1  interleaver output data.
- `il_m_axis_tvalid`  in  1  interleaver output valid.
- `il_m_axis_tlast`  in  1  interleaver output block end.
- `il_m_axis_tready`  out  1  ready to interleaver output.
- `m_axis_tdata`  out  1  forwarded output data.
- `m_axis_tvalid`  out  1  forwarded output valid.
- `m_axis_tlast`  out  1  forwarded block end.
- `m_axis_tuser`  out  `id_width`  source channel ID of the current output block.
- `m_axis_tready`  in  1  downstream ready.
- `grant`  out  `id_width`  channel currently granted; valid while `busy`=1.
- `busy`  out  1  a block transfer is in progress.

## Operation
- State machine has two states: ARB and XFER. Reset state is ARB.
- ARB:
  - If any `s_axis_tvalid` is high and the tag FIFO is not full, select the first requesting channel in round-robin order, starting at `rr_ptr`.
  - Register the selection into `grant`, push it into the tag FIFO, set `rr_ptr` = (`grant`+1) mod `ch_num`, and go to XFER.
  - Otherwise stay in ARB.
  - While in ARB, all `s_axis_tready` = 0 and `il_s_axis_tvalid` = 0.
- XFER:
  - `il_s_axis_tdata` and `il_s_axis_tvalid` are taken from channel `grant`.
  - `s_axis_tready[grant]` = `il_s_axis_tready`; all other readies are 0.
  - `beat_cnt` (width clog2(`row*col`)) increments on each handshake.
  - On the handshake with `beat_cnt` = `row*col`-1: clear `beat_cnt` and go to ARB.
  - The grant is never revoked mid-block, even if the granted channel stalls its valid.
- Tag FIFO:
  - Push happens on the ARB→XFER transition.
  - Pop happens on an output handshake (`m_axis_tvalid` & `m_axis_tready`) with `m_axis_tlast`=1.
  - Simultaneous push and pop is legal: occupancy is unchanged and the head is updated correctly.
  - Full blocks arbitration, which bounds the number of blocks in flight to `tag_deepth`.
- Output forwarding (combinational):
  - `m_axis_tdata` = `il_m_axis_tdata`; `m_axis_tlast` = `il_m_axis_tlast`.
  - `m_axis_tvalid` = `il_m_axis_tvalid` & !fifo_empty.
  - `il_m_axis_tready` = `m_axis_tready` & !fifo_empty.
  - `m_axis_tuser` = FIFO head; it is 0 when the FIFO is empty.
- `busy` = (state == XFER).

## Timing
- Reset values:
  - `s_axis_tready` = 0, `il_s_axis_tvalid` = 0, `il_s_axis_tdata` = 0.
  - `m_axis_tvalid` = 0, `m_axis_tuser` = 0, `il_m_axis_tready` = 0.
  - `grant` = 0, `busy` = 0, `rr_ptr` = 0, `beat_cnt` = 0, tag FIFO empty.
- Arbitration costs exactly one ARB cycle per block, so there is one idle input cycle between back-to-back blocks.
- First data beat can be accepted the cycle after the request is sampled in ARB.
- Input path: `s_axis_tready[grant]` is combinational from `il_s_axis_tready`; no registers are added on the data path.
- Output path: zero latency, no registers except the tag FIFO.
- Reset asserted mid-block aborts the block and the tag FIFO contents. The interleaver must be reset by the same `rst_n`.
- `row*col`=1 is legal: one beat per grant.

## Test plan
Tests use `row`=4, `col`=2 (8 beats per block) and `ch_num`=4.
- Only ch2 is valid continuously, interleaver always ready → two blocks of 8 beats each from ch2 with one ARB gap between them; `grant`=2; output blocks carry `m_axis_tuser`=2 and `tlast` on every 8th beat.
- All four channels are valid continuously → grant order 0,1,2,3,0; each grant lasts exactly 8 handshakes; output `tuser` sequence is 0,1,2,3.
- Only ch1 and ch3 are valid → grant order 1,3,1,3; ch0 and ch2 readies stay 0 throughout.
- Granted channel drops valid for 5 cycles mid-block → grant is held, `beat_cnt` freezes, and the block completes with exactly 8 beats.
- `m_axis_tready`=0 while inputs keep arriving → after `tag_deepth` blocks the block stays in ARB with all readies 0; releasing `tready` pops tags in order and arbitration resumes.
- `rst_n` is pulsed low at beat 3 of a ch1 block → all outputs return to reset values asynchronously; after release the next grant starts from ch0.
